// File: rtl/autobaud_detector.sv
// Measures the bit time of a 0x55 training character and produces the UART clock divider.
// Optional 3-sample majority glitch filter on serial_i: define AUTOBAUD_GLITCH_FILTER_EN.
`timescale 1ns/1ps
module autobaud_detector #(
    parameter int DIVIDER_WIDTH   = 7,
    parameter int COUNT_WIDTH     = DIVIDER_WIDTH + 4,
    parameter int DEFAULT_DIVIDER = 87,
    parameter int MIN_DIVIDER     = 4,
    parameter int IDLE_CYCLES     = 1024
) (
    input  logic                     clock_i,
    input  logic                     reset_n_i,
    input  logic                     serial_i,
    input  logic                     start_i,
    output logic [DIVIDER_WIDTH-1:0] clock_divider_o,
    output logic                     locked_o,
    output logic                     error_o,
    output logic                     busy_o
);
    localparam int IDLE_WIDTH = $clog2(IDLE_CYCLES + 1);
    localparam int CW1        = COUNT_WIDTH + 1;

    localparam logic [2:0] ST_IDLE_WAIT = 3'd0;
    localparam logic [2:0] ST_ARMED     = 3'd1;
    localparam logic [2:0] ST_MEASURE   = 3'd2;
    localparam logic [2:0] ST_CHECK     = 3'd3;
    localparam logic [2:0] ST_LOCKED    = 3'd4;

    localparam logic [IDLE_WIDTH-1:0]    IDLE_TARGET = IDLE_WIDTH'(IDLE_CYCLES);
    localparam logic [COUNT_WIDTH-1:0]   COUNT_MAX   = '1;
    localparam logic [CW1-1:0]           DIV_MIN     = CW1'(MIN_DIVIDER);
    localparam logic [CW1-1:0]           DIV_MAX     = CW1'((1 << DIVIDER_WIDTH) - 1);
    localparam logic [DIVIDER_WIDTH-1:0] DIV_RESET   = DIVIDER_WIDTH'(DEFAULT_DIVIDER);

    logic line;

`ifdef AUTOBAUD_GLITCH_FILTER_EN
    logic [2:0] filt_reg;

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            filt_reg <= 3'b111;
        end else begin
            filt_reg <= {filt_reg[1:0], serial_i};
        end
    end

    // 2-of-3 vote: a single low sample never wins, every edge is delayed by two cycles
    assign line = (filt_reg[0] & filt_reg[1]) | (filt_reg[0] & filt_reg[2]) |
                  (filt_reg[1] & filt_reg[2]);
`else
    assign line = serial_i;
`endif

    logic                     prev_reg;
    logic [2:0]               state_reg, state_next;
    logic [IDLE_WIDTH-1:0]    idle_reg, idle_next;
    logic [COUNT_WIDTH-1:0]   count_reg, count_next;
    logic [COUNT_WIDTH-1:0]   last_reg, last_next;
    logic [COUNT_WIDTH-1:0]   ref_reg, ref_next;
    logic [COUNT_WIDTH-1:0]   total_reg, total_next;
    logic [2:0]               k_reg, k_next;
    logic [DIVIDER_WIDTH-1:0] div_reg, div_next;
    logic                     locked_reg, locked_next;
    logic                     error_reg, error_next;
    logic                     busy_reg, busy_next;

    logic                     fall;
    logic [COUNT_WIDTH-1:0]   count_inc;
    logic [COUNT_WIDTH-1:0]   interval;
    logic [COUNT_WIDTH-1:0]   diff;
    logic                     tol_bad;
    logic [CW1-1:0]           div_full;
    logic                     reject;

    assign fall      = prev_reg & ~line;
    // The value seen at an edge already includes the current cycle, so the 2-bit interval reads 2T
    assign count_inc = (count_reg == COUNT_MAX) ? COUNT_MAX : count_reg + 1'b1;
    assign interval  = count_inc - last_reg;
    assign diff      = (interval >= ref_reg) ? (interval - ref_reg) : (ref_reg - interval);
    assign tol_bad   = diff > (ref_reg >> 3);
    assign div_full  = (CW1'(total_reg) + CW1'(4)) >> 3;

    always_comb begin
        state_next  = state_reg;
        idle_next   = idle_reg;
        count_next  = count_reg;
        last_next   = last_reg;
        ref_next    = ref_reg;
        total_next  = total_reg;
        k_next      = k_reg;
        div_next    = div_reg;
        locked_next = locked_reg;
        busy_next   = busy_reg;
        error_next  = 1'b0;
        reject      = 1'b0;

        case (state_reg)
            ST_IDLE_WAIT: begin
                if (!line) begin
                    idle_next = '0;
                end else if (idle_reg + 1'b1 == IDLE_TARGET) begin
                    idle_next  = '0;
                    state_next = ST_ARMED;
                end else begin
                    idle_next = idle_reg + 1'b1;
                end
            end
            ST_ARMED: begin
                if (fall) begin
                    state_next  = ST_MEASURE;
                    count_next  = '0;
                    last_next   = '0;
                    k_next      = 3'd0;
                    busy_next   = 1'b1;
                    locked_next = 1'b0;
                end
            end
            ST_MEASURE: begin
                count_next = count_inc;
                if (count_inc == COUNT_MAX) begin
                    reject = 1'b1;
                end else if (fall) begin
                    k_next    = k_reg + 3'd1;
                    last_next = count_inc;
                    if (k_reg == 3'd0) begin
                        ref_next = interval;
                    end else if (tol_bad) begin
                        reject = 1'b1;
                    end else if (k_reg == 3'd3) begin
                        total_next = count_inc;
                        state_next = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                if (div_full < DIV_MIN || div_full > DIV_MAX) begin
                    reject = 1'b1;
                end else begin
                    div_next    = div_full[DIVIDER_WIDTH-1:0];
                    locked_next = 1'b1;
                    busy_next   = 1'b0;
                    state_next  = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                state_next = ST_LOCKED;
            end
            default: begin
                state_next = ST_IDLE_WAIT;
                idle_next  = '0;
            end
        endcase

        if (reject) begin
            error_next  = 1'b1;
            busy_next   = 1'b0;
            locked_next = 1'b0;
            state_next  = ST_IDLE_WAIT;
            idle_next   = '0;
        end

        // Re-arm wins over any edge or result arriving in the same cycle
        if (start_i) begin
            state_next  = ST_IDLE_WAIT;
            idle_next   = '0;
            busy_next   = 1'b0;
            error_next  = 1'b0;
            locked_next = locked_reg;
            div_next    = div_reg;
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            prev_reg   <= 1'b1;
            state_reg  <= ST_IDLE_WAIT;
            idle_reg   <= '0;
            count_reg  <= '0;
            last_reg   <= '0;
            ref_reg    <= '0;
            total_reg  <= '0;
            k_reg      <= 3'd0;
            div_reg    <= DIV_RESET;
            locked_reg <= 1'b0;
            error_reg  <= 1'b0;
            busy_reg   <= 1'b0;
        end else begin
            prev_reg   <= line;
            state_reg  <= state_next;
            idle_reg   <= idle_next;
            count_reg  <= count_next;
            last_reg   <= last_next;
            ref_reg    <= ref_next;
            total_reg  <= total_next;
            k_reg      <= k_next;
            div_reg    <= div_next;
            locked_reg <= locked_next;
            error_reg  <= error_next;
            busy_reg   <= busy_next;
        end
    end

    assign clock_divider_o = div_reg;
    assign locked_o        = locked_reg;
    assign error_o         = error_reg;
    assign busy_o          = busy_reg;
endmodule

// File: tb/tb_autobaud_detector.sv
// Self-checking bench for autobaud_detector: vector table, random frames vs. edge-time model,
// and hand sequences for timeout, abort, reset and (when enabled) the glitch filter.
`timescale 1ns/1ps
module tb_autobaud_detector;
`ifdef AUTOBAUD_GLITCH_FILTER_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif
    localparam int IDLE_RUN = 1040;

    logic       clock_i   = 1'b0;
    logic       reset_n_i = 1'b0;
    logic       serial_i  = 1'b1;
    logic       start_i   = 1'b0;
    logic [6:0] clock_divider_o;
    logic       locked_o;
    logic       error_o;
    logic       busy_o;

    autobaud_detector dut (
        .clock_i        (clock_i),
        .reset_n_i      (reset_n_i),
        .serial_i       (serial_i),
        .start_i        (start_i),
        .clock_divider_o(clock_divider_o),
        .locked_o       (locked_o),
        .error_o        (error_o),
        .busy_o         (busy_o)
    );

    always #5 clock_i = ~clock_i;

    typedef struct {
        int bit_t;
        int iv3;
        int exp_lock;
        int exp_div;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int err_q[$];
    int lock_cycle = -1;
    int busy_first = -1;
    bit prev_locked = 1'b0;
    int model_div = 87;
    int ev[5];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock: drive at negedge, observe just after posedge (values valid in cycle c+1)
    task automatic tick(input logic s, input logic st);
        int c;
        @(negedge clock_i);
        serial_i = s;
        start_i  = st;
        c = cyc;
        @(posedge clock_i);
        #1;
        cyc++;
        if (error_o) err_q.push_back(c + 1);
        if (locked_o && !prev_locked && lock_cycle < 0) lock_cycle = c + 1;
        if (busy_o && busy_first < 0) busy_first = c + 1;
        prev_locked = locked_o;
    endtask

    task automatic arm();
        tick(1'b1, 1'b1);
        repeat (IDLE_RUN) tick(1'b1, 1'b0);
    endtask

    // Outcome from falling-edge times alone: kind 0 = lock, 1 = reject
    task automatic model(input int n, output int kind, output int at, output int dv);
        int iv, rf, d;
        kind = 1;
        dv   = -1;
        rf   = 0;
        for (int k = 1; k <= 4; k++) begin
            if (k >= n || ev[k] >= 2047) begin
                at = 2048 + LAT;
                return;
            end
            iv = ev[k] - ev[k-1];
            if (k == 1) begin
                rf = iv;
            end else begin
                d = (iv > rf) ? iv - rf : rf - iv;
                if (d > rf / 8) begin
                    at = ev[k] + 1 + LAT;
                    return;
                end
            end
        end
        dv = (ev[4] + 4) / 8;
        at = ev[4] + 2 + LAT;
        if (dv < 4 || dv > 127) return;
        kind = 0;
    endtask

    // kind 0 = lock, 1 = reject, 2 = aborted by start_i (no event)
    task automatic run_frame(input string name, input int n, input int w, input int start_at,
                             input int exp_kind, input int exp_at, input int exp_div);
        int  base, span;
        bit  low;
        arm();
        err_q.delete();
        lock_cycle = -1;
        busy_first = -1;
        base = cyc;
        span = ((n == 1) ? w : ev[n-1] + w) + 12;
        for (int i = 0; i < span; i++) begin
            low = 1'b0;
            for (int j = 0; j < n; j++) begin
                if (i >= ev[j] && i < ev[j] + w && (j == n - 1 || i < ev[j+1] - 1)) low = 1'b1;
            end
            tick(~low, (i == start_at));
        end
        check({name, "_busy_start"}, busy_first, base + 1 + LAT);
        check({name, "_busy_end"}, busy_o, 0);
        if (exp_kind == 0) begin
            model_div = exp_div;
            check({name, "_lock_at"}, lock_cycle, base + exp_at);
            check({name, "_no_error"}, err_q.size(), 0);
        end else if (exp_kind == 1) begin
            check({name, "_error_count"}, err_q.size(), 1);
            if (err_q.size() > 0) check({name, "_error_at"}, err_q[0], base + exp_at);
            check({name, "_no_lock"}, lock_cycle, -1);
        end else begin
            check({name, "_no_error"}, err_q.size(), 0);
            check({name, "_no_lock"}, lock_cycle, -1);
        end
        check({name, "_divider"}, clock_divider_o, model_div);
        check({name, "_locked"}, locked_o, (exp_kind == 0) ? 1 : 0);
        $display("frame %s: edges=%0d expect kind=%0d div=%0d got div=%0d locked=%0d errors=%0d",
                 name, n, exp_kind, model_div, clock_divider_o, locked_o, err_q.size());
    endtask

    task automatic set_nominal(input int t, input int iv3);
        ev[0] = 0;
        ev[1] = 2 * t;
        ev[2] = 4 * t;
        ev[3] = ev[2] + ((iv3 != 0) ? iv3 : 2 * t);
        ev[4] = ev[3] + 2 * t;
    endtask

    vec_t vecs[7];

    initial begin
        int kind, at, dv, t;

        vecs[0] = '{87, 0, 1, 87};
        vecs[1] = '{12, 0, 1, 12};
        vecs[2] = '{100, 0, 1, 100};
        vecs[3] = '{87, 200, 0, -1};
        vecs[4] = '{87, 195, 1, 90};
        vecs[5] = '{3, 0, 0, -1};
        vecs[6] = '{130, 0, 0, -1};

        repeat (3) @(posedge clock_i);
        #1;
        check("reset_divider", clock_divider_o, 87);
        check("reset_locked", locked_o, 0);
        check("reset_busy", busy_o, 0);
        check("reset_error", error_o, 0);
        @(negedge clock_i);
        reset_n_i = 1'b1;

        for (int i = 0; i < 7; i++) begin
            set_nominal(vecs[i].bit_t, vecs[i].iv3);
            at = (vecs[i].iv3 == 200) ? ev[3] + 1 + LAT : ev[4] + 2 + LAT;
            run_frame($sformatf("vec%0d_T%0d", i, vecs[i].bit_t), 5, vecs[i].bit_t, -1,
                      vecs[i].exp_lock ? 0 : 1, at, vecs[i].exp_div);
        end

        for (int r = 0; r < 8; r++) begin
            t = $urandom_range(3, 135);
            set_nominal(t, 0);
            if (t >= 8) begin
                for (int k = 1; k < 5; k++) ev[k] = ev[k] + $urandom_range(0, 8) - 4;
                if ($urandom_range(0, 3) == 0) begin
                    for (int k = 3; k < 5; k++) ev[k] = ev[k] + t / 3;
                end
            end
            model(5, kind, at, dv);
            run_frame($sformatf("rand%0d_T%0d", r, t), 5, t, -1, kind, at, dv);
        end

        ev[0] = 0;
        run_frame("timeout", 1, 2100, -1, 1, 2048 + LAT, -1);

        set_nominal(87, 0);
        run_frame("abort_measure", 5, 87, 300, 2, 0, -1);

        set_nominal(20, 0);
        run_frame("abort_check", 5, 20, 161 + LAT, 2, 0, -1);

`ifdef AUTOBAUD_GLITCH_FILTER_EN
        arm();
        busy_first = -1;
        err_q.delete();
        tick(1'b0, 1'b0);
        repeat (20) tick(1'b1, 1'b0);
        check("glitch_no_busy", busy_first, -1);
        check("glitch_no_error", err_q.size(), 0);
        $display("glitch pulse in armed: busy_first=%0d", busy_first);
`endif

        set_nominal(60, 0);
        run_frame("pre_reset", 5, 60, -1, 0, ev[4] + 2 + LAT, 60);

        arm();
        repeat (40) tick(1'b0, 1'b0);
        check("midmeasure_busy", busy_o, 1);
        @(negedge clock_i);
        #2;
        reset_n_i = 1'b0;
        #1;
        check("async_reset_divider", clock_divider_o, 87);
        check("async_reset_locked", locked_o, 0);
        check("async_reset_busy", busy_o, 0);
        check("async_reset_error", error_o, 0);
        model_div = 87;
        $display("async reset mid-measure: div=%0d locked=%0d busy=%0d", clock_divider_o, locked_o, busy_o);
        @(negedge clock_i);
        reset_n_i = 1'b1;
        serial_i  = 1'b1;
        repeat (4) @(posedge clock_i);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
